// File: rtl/aes_gf_pkg.sv
// Shared constants and FSM state type for the AES GF(2^8) inverse/divide unit.
// Define GF_DIVIDE_EN to add the MULN state (result = in_num * in_data^-1).
package aes_gf_pkg;

  localparam logic [7:0] AES_POLY     = 8'h1B;
  localparam logic [2:0] GF_INV_STEPS = 3'd7;

`ifdef GF_DIVIDE_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_MULN = 2'd3
  } gf_inv_state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } gf_inv_state_t;
`endif

endpackage

// File: rtl/gf_mul_comb.sv
// Combinational GF(2^8) multiplier, AES polynomial x^8+x^4+x^3+x+1.
// Ports: a_i, b_i operands; p_o = a_i * b_i mod 0x11B.
module gf_mul_comb
  import aes_gf_pkg::*;
(
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  output logic [7:0] p_o
);

  logic [7:0] p;
  logic [7:0] t;

  // Shift-and-add: t walks a_i * x^i, reduced each step.
  always_comb begin
    p = 8'h00;
    t = a_i;
    for (int i = 0; i < 8; i++) begin
      if (b_i[i]) p = p ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? AES_POLY : 8'h00);
    end
  end

  assign p_o = p;

endmodule

// File: rtl/gf_inverse.sv
// Sequential GF(2^8) inverse (a^254) by square-and-multiply, valid/ready I/O.
// Ports: clk, rst_n, in_valid/in_ready/in_data/in_num, out_valid/out_ready/out_data, busy.
// Macro GF_DIVIDE_EN: capture in_num and output in_num * in_data^-1.
module gf_inverse
  import aes_gf_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic [7:0] in_num,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       busy
);

  gf_inv_state_t state_q;
  logic [7:0]    sq_q;
  logic [7:0]    acc_q;
  logic [2:0]    step_q;
  logic [7:0]    out_data_q;
  logic          out_valid_q;

  logic [7:0]    sq2;
  logic [7:0]    mul_a;
  logic [7:0]    mul_b;
  logic [7:0]    prod;

`ifdef GF_DIVIDE_EN
  logic [7:0]    num_q;

  // MULN borrows the acc-path multiplier for num * acc.
  always_comb begin
    mul_a = acc_q;
    mul_b = sq2;
    if (state_q == ST_MULN) begin
      mul_a = num_q;
      mul_b = acc_q;
    end
  end
`else
  logic unused_num;
  assign unused_num = ^in_num;
  assign mul_a      = acc_q;
  assign mul_b      = sq2;
`endif

  gf_mul_comb u_mul_sq (
    .a_i (sq_q),
    .b_i (sq_q),
    .p_o (sq2)
  );

  gf_mul_comb u_mul_acc (
    .a_i (mul_a),
    .b_i (mul_b),
    .p_o (prod)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      sq_q        <= 8'h00;
      acc_q       <= 8'h00;
      step_q      <= 3'd0;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
`ifdef GF_DIVIDE_EN
      num_q       <= 8'h00;
`endif
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            sq_q    <= in_data;
            acc_q   <= 8'h01;
            step_q  <= 3'd1;
            state_q <= ST_RUN;
`ifdef GF_DIVIDE_EN
            num_q   <= in_num;
`endif
          end
        end
        ST_RUN: begin
          // acc collects a^2, a^4, ..., a^128 -> a^254 after 7 steps.
          sq_q   <= sq2;
          acc_q  <= prod;
          step_q <= step_q + 3'd1;
          if (step_q == GF_INV_STEPS) begin
`ifdef GF_DIVIDE_EN
            state_q     <= ST_MULN;
`else
            out_data_q  <= prod;
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
`endif
          end
        end
`ifdef GF_DIVIDE_EN
        ST_MULN: begin
          out_data_q  <= prod;
          out_valid_q <= 1'b1;
          state_q     <= ST_DONE;
        end
`endif
        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule
